// File: rtl/lock_datapath_if.sv
// Signal bundle between the keypad-lock FSM (master) and its datapath front end (slave).
// Slide-switch word and FSM strobes flow in; conditioned Enter, match and lockout status flow out.
interface lock_datapath_if #(
   parameter int DATA_W = 4,
   parameter int FC_W   = 2
);
   logic [DATA_W-1:0] SW;
   logic              savePW;
   logic              saveAT;
   logic              LOCKED;
   logic              E;
   logic              M;
   logic              lockout;
   logic [FC_W-1:0]   fail_count;

   modport master (
      output SW, savePW, saveAT, LOCKED,
      input  E, M, lockout, fail_count
   );

   modport slave (
      input  SW, savePW, saveAT, LOCKED,
      output E, M, lockout, fail_count
   );
endinterface

// File: rtl/lock_datapath.sv
// Keypad-lock front end: Enter synchroniser/debouncer, password/attempt registers,
// match flag, failed-attempt counter and timed lockout that masks Enter.
module lock_datapath #(
   parameter int DATA_W          = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_FAILS       = 3,
   parameter int LOCKOUT_CYCLES  = 250000000,
   parameter int FC_W            = $clog2(MAX_FAILS + 1)
) (
   input  logic            clk,
   input  logic            RESETN,
   input  logic            KEY_ENTER_N,
   lock_datapath_if.slave  bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int LT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LT_W-1:0] LT_LAST  = LT_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_LIMIT = FC_W'(MAX_FAILS);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_LOCKOUT = 1'b1
   } lock_state_e;

   logic              sync1_q, sync2_q;
   logic              deb_q, deb_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [DATA_W-1:0] pw_q, pw_d;
   logic [DATA_W-1:0] at_q, at_d;
   logic              save_at_q;
   logic [FC_W-1:0]   fc_q, fc_d;
   logic [FC_W-1:0]   fc_inc;
   logic [LT_W-1:0]   timer_q, timer_d;
   lock_state_e       state_q, state_d;

   logic              lockout_w;
   logic              end_attempt;

   assign lockout_w   = (state_q == ST_LOCKOUT);
   assign end_attempt = save_at_q & ~bus.saveAT;
   assign fc_inc      = (fc_q == FC_LIMIT) ? fc_q : fc_q + FC_W'(1);

   // Debounce: the counter only runs while the synced sample disagrees with the accepted level.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      deb_d    = deb_q;
      db_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (db_cnt_q == DB_LAST) begin
            deb_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   // savePW outranks saveAT; both registers freeze while locked out.
   always_comb begin
      pw_d = pw_q;
      at_d = at_q;
      if (!lockout_w) begin
         if (bus.savePW) begin
            pw_d = bus.SW;
         end else if (bus.saveAT) begin
            at_d = bus.SW;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      fc_d    = fc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.savePW) begin
               fc_d = '0;
            end else if (end_attempt) begin
               if (bus.LOCKED) begin
                  fc_d = fc_inc;
                  if (fc_inc == FC_LIMIT) begin
                     state_d = ST_LOCKOUT;
                     timer_d = '0;
                  end
               end else begin
                  fc_d = '0;
               end
            end
         end
         ST_LOCKOUT: begin
            // Expiry also forgives the failures that caused the lockout.
            if (timer_q == LT_LAST) begin
               state_d = ST_IDLE;
               timer_d = '0;
               fc_d    = '0;
            end else begin
               timer_d = timer_q + LT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
            fc_d    = '0;
         end
      endcase
   end

   // Synchroniser and debounced level idle at 1 because the button is active-low.
   always_ff @(posedge clk or negedge RESETN) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (!RESETN) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         deb_q     <= 1'b1;
         db_cnt_q  <= '0;
         pw_q      <= '0;
         at_q      <= '0;
         save_at_q <= 1'b0;
         fc_q      <= '0;
         timer_q   <= '0;
         state_q   <= ST_IDLE;
      end else begin
         sync1_q   <= KEY_ENTER_N;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         db_cnt_q  <= db_cnt_d;
         pw_q      <= pw_d;
         at_q      <= at_d;
         save_at_q <= bus.saveAT;
         fc_q      <= fc_d;
         timer_q   <= timer_d;
         state_q   <= state_d;
      end
   end

   assign bus.E          = ~deb_q & ~lockout_w;
   assign bus.M          = (at_q == pw_q);
   assign bus.lockout    = lockout_w;
   assign bus.fail_count = fc_q;

endmodule

// File: tb/tb_lock_datapath.sv
// Directed bench for lock_datapath with short debounce/lockout constants:
// a vector table for capture/match/counting plus hand sequences for debounce, lockout and reset.
module tb_lock_datapath;

   localparam int DATA_W          = 4;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int MAX_FAILS       = 3;
   localparam int LOCKOUT_CYCLES  = 16;
   localparam int FC_W            = $clog2(MAX_FAILS + 1);

   logic clk = 1'b0;
   logic RESETN;
   logic KEY_ENTER_N;

   int n_vec = 0;
   int n_bad = 0;

   lock_datapath_if #(.DATA_W(DATA_W), .FC_W(FC_W)) bus ();

   lock_datapath #(
      .DATA_W          (DATA_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .MAX_FAILS       (MAX_FAILS),
      .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
      .FC_W            (FC_W)
   ) dut (
      .clk         (clk),
      .RESETN      (RESETN),
      .KEY_ENTER_N (KEY_ENTER_N),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [DATA_W-1:0] sw;
      logic              spw;
      logic              sat;
      logic              lkd;
      logic              e;
      logic              m;
      logic              lo;
      logic [FC_W-1:0]   fc;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic e, input logic m,
                            input logic lo, input logic [FC_W-1:0] fc);
      check({name, ".E"}, 32'(bus.E), 32'(e));
      check({name, ".M"}, 32'(bus.M), 32'(m));
      check({name, ".lockout"}, 32'(bus.lockout), 32'(lo));
      check({name, ".fail_count"}, 32'(bus.fail_count), 32'(fc));
   endtask

   // Advance one edge; outputs are then sampled 2 time units after it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [DATA_W-1:0] sw, input logic spw, input logic sat, input logic lkd);
      bus.SW     = sw;
      bus.savePW = spw;
      bus.saveAT = sat;
      bus.LOCKED = lkd;
   endtask

   // One failed attempt (SW=3 against pw=5): strobe saveAT, then let it fall with LOCKED=1.
   task automatic fail_attempt(input string name, input logic exp_e, input logic exp_lo,
                               input logic [FC_W-1:0] exp_fc);
      drive(4'h3, 1'b0, 1'b1, 1'b1);
      tick();
      drive(4'h3, 1'b0, 1'b0, 1'b1);
      tick();
      check_all(name, exp_e, 1'b0, exp_lo, exp_fc);
   endtask

   task automatic async_reset(input string name);
      #1;
      RESETN = 1'b0;
      #1;
      check_all(name, 1'b0, 1'b1, 1'b0, '0);
      #3;
      RESETN = 1'b1;
      drive(4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
      tbl[2]  = '{4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
      tbl[3]  = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[4]  = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[5]  = '{4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[6]  = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[7]  = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[8]  = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[9]  = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[10] = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
      tbl[11] = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[12] = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};

      RESETN      = 1'b0;
      KEY_ENTER_N = 1'b1;
      drive(4'h0, 1'b0, 1'b0, 1'b0);
      #12;
      check_all("reset", 1'b0, 1'b1, 1'b0, '0);
      #4;
      RESETN = 1'b1;
      tick();
      check_all("post_reset", 1'b0, 1'b1, 1'b0, '0);

      // Bounce: two low cycles must not get through the debouncer.
      KEY_ENTER_N = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) KEY_ENTER_N = 1'b1;
         tick();
         check($sformatf("bounce_E[%0d]", i), 32'(bus.E), 32'd0);
      end
      KEY_ENTER_N = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("press_E[%0d]", i), 32'(bus.E), 32'(i == 6));
      end
      KEY_ENTER_N = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("release_E[%0d]", i), 32'(bus.E), 32'(i < 6));
      end

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].sw, tbl[i].spw, tbl[i].sat, tbl[i].lkd);
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].e, tbl[i].m, tbl[i].lo, tbl[i].fc);
      end
      drive(4'h5, 1'b0, 1'b0, 1'b0);

      // Lockout with the button held throughout.
      KEY_ENTER_N = 1'b0;
      repeat (6) tick();
      check("held_E", 32'(bus.E), 32'd1);
      fail_attempt("lk_fail1", 1'b1, 1'b0, 2'd1);
      fail_attempt("lk_fail2", 1'b1, 1'b0, 2'd2);
      fail_attempt("lk_fail3", 1'b0, 1'b1, 2'd3);
      for (int i = 1; i <= 15; i++) begin
         drive(4'h5, 1'b0, (i == 3), 1'b1);
         tick();
         check_all($sformatf("locked[%0d]", i), 1'b0, 1'b0, 1'b1, 2'd3);
      end
      drive(4'h5, 1'b0, 1'b0, 1'b0);
      tick();
      check_all("expiry", 1'b1, 1'b0, 1'b0, 2'd0);

      // Reset while a release is being debounced.
      fail_attempt("db_fail1", 1'b1, 1'b0, 2'd1);
      fail_attempt("db_fail2", 1'b1, 1'b0, 2'd2);
      KEY_ENTER_N = 1'b1;
      repeat (3) tick();
      check("mid_debounce_E", 32'(bus.E), 32'd1);
      async_reset("reset_mid_debounce");
      tick();
      check_all("after_reset1", 1'b0, 1'b1, 1'b0, '0);

      // Reset in the middle of a lockout.
      drive(4'h5, 1'b1, 1'b0, 1'b0);
      tick();
      check("pw_set_M", 32'(bus.M), 32'd0);
      fail_attempt("rl_fail1", 1'b0, 1'b0, 2'd1);
      fail_attempt("rl_fail2", 1'b0, 1'b0, 2'd2);
      fail_attempt("rl_fail3", 1'b0, 1'b1, 2'd3);
      drive(4'h3, 1'b0, 1'b0, 1'b0);
      repeat (5) tick();
      check("mid_lockout", 32'(bus.lockout), 32'd1);
      async_reset("reset_mid_lockout");
      tick();
      check_all("after_reset2", 1'b0, 1'b1, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
